// File: rtl/pipelined_chunk_adder.sv
// pipelined_chunk_adder: a WIDTH-bit add/subtract split into CHUNK-bit slices.
// Each pipeline stage adds one slice and registers the carry into the next
// stage. All stages advance together under a single valid/ready handshake.
// The last stage doubles as the output register, so the sum is available
// NSTAGES cycles after the operands are presented.
module pipelined_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             SUB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             OVF
);

  localparam int NSTAGES = WIDTH / CHUNK;
  localparam int LAST    = NSTAGES - 1;

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("pipelined_chunk_adder: WIDTH must be a multiple of CHUNK");
  end

  // Stage registers; index LAST is the output register.
  logic             vld_r [NSTAGES];
  logic [WIDTH-1:0] a_r   [NSTAGES];
  logic [WIDTH-1:0] b_r   [NSTAGES];
  logic [WIDTH-1:0] sum_r [NSTAGES];
  logic             c_r   [NSTAGES];
  logic             ovf_r;

  // Next-state values for each stage.
  logic             vld_n [NSTAGES];
  logic [WIDTH-1:0] a_n   [NSTAGES];
  logic [WIDTH-1:0] b_n   [NSTAGES];
  logic [WIDTH-1:0] sum_n [NSTAGES];
  logic             c_n   [NSTAGES];
  logic             ovf_n;

  logic             adv;
  logic             unused_last;

  // Every stage moves forward together, unless a finished result is stalled at the output
  assign adv       = !vld_r[LAST] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_r[LAST];
  assign S         = sum_r[LAST];
  assign Cout      = c_r[LAST];
  assign OVF       = ovf_r;

  // The operand copies in the output stage are only used to compute OVF one step earlier
  assign unused_last = ^{a_r[LAST], b_r[LAST]};

  // Add one CHUNK-bit slice per stage using the carry registered by the stage before
  always_comb begin
    logic             v_src;
    logic [WIDTH-1:0] a_src;
    logic [WIDTH-1:0] b_src;
    logic [WIDTH-1:0] s_src;
    logic             c_src;
    logic [CHUNK:0]   slice;
    int               prev;
    v_src = 1'b0;
    a_src = {WIDTH{1'b0}};
    b_src = {WIDTH{1'b0}};
    s_src = {WIDTH{1'b0}};
    c_src = 1'b0;
    slice = {(CHUNK+1){1'b0}};
    prev  = 0;
    for (int k = 0; k < NSTAGES; k++) begin
      prev = (k == 0) ? 0 : k - 1;
      if (k == 0) begin
        // Subtract is A + ~B + ~borrow; the borrow-in is inverted into a carry-in.
        v_src = in_valid;
        a_src = A;
        b_src = SUB ? ~B : B;
        s_src = {WIDTH{1'b0}};
        c_src = SUB ? ~Cin : Cin;
      end else begin
        v_src = vld_r[prev];
        a_src = a_r[prev];
        b_src = b_r[prev];
        s_src = sum_r[prev];
        c_src = c_r[prev];
      end
      slice = {1'b0, a_src[k*CHUNK +: CHUNK]}
            + {1'b0, b_src[k*CHUNK +: CHUNK]}
            + {{CHUNK{1'b0}}, c_src};
      vld_n[k] = v_src;
      a_n[k]   = a_src;
      b_n[k]   = b_src;
      sum_n[k] = s_src;
      sum_n[k][k*CHUNK +: CHUNK] = slice[CHUNK-1:0];
      c_n[k]   = slice[CHUNK];
    end
    // Signed overflow: operands share a sign that the result does not.
    ovf_n = (a_n[LAST][WIDTH-1] == b_n[LAST][WIDTH-1]) &&
            (sum_n[LAST][WIDTH-1] != a_n[LAST][WIDTH-1]);
  end

  // Shift all stages on advance; the output stage only loads when a valid result arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSTAGES; k++) begin
        vld_r[k] <= 1'b0;
        a_r[k]   <= {WIDTH{1'b0}};
        b_r[k]   <= {WIDTH{1'b0}};
        sum_r[k] <= {WIDTH{1'b0}};
        c_r[k]   <= 1'b0;
      end
      ovf_r <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < NSTAGES; k++) begin
        vld_r[k] <= vld_n[k];
        if ((k != LAST) || vld_n[k]) begin
          a_r[k]   <= a_n[k];
          b_r[k]   <= b_n[k];
          sum_r[k] <= sum_n[k];
          c_r[k]   <= c_n[k];
        end
      end
      if (vld_n[LAST]) begin
        ovf_r <= ovf_n;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_chunk_adder.sv
// Self-checking bench for pipelined_chunk_adder: three instances (16/4, 8/8,
// 32/8) checked against an arithmetic reference model through per-instance
// scoreboards, plus directed cycle-exact latency, stall and reset checks.
module tb_pipelined_chunk_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  // 16-bit, 4-bit chunk instance
  logic        u16_in_valid, u16_in_ready, u16_out_valid, u16_out_ready;
  logic [15:0] u16_A, u16_B, u16_S;
  logic        u16_Cin, u16_SUB, u16_Cout, u16_OVF;
  // 8-bit, single stage instance
  logic        u8_in_valid, u8_in_ready, u8_out_valid, u8_out_ready;
  logic [7:0]  u8_A, u8_B, u8_S;
  logic        u8_Cin, u8_SUB, u8_Cout, u8_OVF;
  // 32-bit, 8-bit chunk instance
  logic        u32_in_valid, u32_in_ready, u32_out_valid, u32_out_ready;
  logic [31:0] u32_A, u32_B, u32_S;
  logic        u32_Cin, u32_SUB, u32_Cout, u32_OVF;

  logic [33:0] q16[$];
  logic [33:0] q8[$];
  logic [33:0] q32[$];
  int          n16 = 0;
  int          n8 = 0;
  int          n32 = 0;
  bit          done32 = 1'b0;

  pipelined_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_d16 (
    .clk(clk), .rst_n(rst_n), .in_valid(u16_in_valid), .in_ready(u16_in_ready),
    .A(u16_A), .B(u16_B), .Cin(u16_Cin), .SUB(u16_SUB),
    .out_valid(u16_out_valid), .out_ready(u16_out_ready),
    .S(u16_S), .Cout(u16_Cout), .OVF(u16_OVF));

  pipelined_chunk_adder #(.WIDTH(8), .CHUNK(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(u8_in_valid), .in_ready(u8_in_ready),
    .A(u8_A), .B(u8_B), .Cin(u8_Cin), .SUB(u8_SUB),
    .out_valid(u8_out_valid), .out_ready(u8_out_ready),
    .S(u8_S), .Cout(u8_Cout), .OVF(u8_OVF));

  pipelined_chunk_adder #(.WIDTH(32), .CHUNK(8)) u_d32 (
    .clk(clk), .rst_n(rst_n), .in_valid(u32_in_valid), .in_ready(u32_in_ready),
    .A(u32_A), .B(u32_B), .Cin(u32_Cin), .SUB(u32_SUB),
    .out_valid(u32_out_valid), .out_ready(u32_out_ready),
    .S(u32_S), .Cout(u32_Cout), .OVF(u32_OVF));

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: integer arithmetic; returns {OVF, Cout, S zero-extended to 32 bits}
  function automatic logic [33:0] model(int w, longint a, longint b, logic cin, logic sub);
    longint ci, full, half, r, sa, sb, rs;
    logic   co, ov;
    ci   = cin ? 64'sd1 : 64'sd0;
    full = 64'sd1 << w;
    half = 64'sd1 << (w - 1);
    sa   = (a >= half) ? a - full : a;
    sb   = (b >= half) ? b - full : b;
    if (sub) begin
      r  = a - b - ci;
      co = (r >= 64'sd0);
      rs = sa - sb - ci;
    end else begin
      r  = a + b + ci;
      co = (r >= full);
      rs = sa + sb + ci;
    end
    ov = (rs >= half) || (rs < -half);
    r  = r & (full - 64'sd1);
    return {ov, co, r[31:0]};
  endfunction

  // Scoreboard 16/4: check the head result every valid cycle, pop on drain, push on accept
  always @(negedge clk) begin
    if (!rst_n) begin
      q16.delete();
    end else begin
      if (u16_out_valid) begin
        chk("u16 result expected", 64'(q16.size() != 0), 64'd1);
        if (q16.size() != 0) begin
          chk("u16 result", {u16_OVF, u16_Cout, 16'h0, u16_S}, q16[0]);
          if (u16_out_ready) begin
            void'(q16.pop_front());
            n16++;
          end
        end
      end
      if (u16_in_valid && u16_in_ready)
        q16.push_back(model(16, u16_A, u16_B, u16_Cin, u16_SUB));
    end
  end

  // Scoreboard 8/8
  always @(negedge clk) begin
    if (!rst_n) begin
      q8.delete();
    end else begin
      if (u8_out_valid) begin
        chk("u8 result expected", 64'(q8.size() != 0), 64'd1);
        if (q8.size() != 0) begin
          chk("u8 result", {u8_OVF, u8_Cout, 24'h0, u8_S}, q8[0]);
          if (u8_out_ready) begin
            void'(q8.pop_front());
            n8++;
          end
        end
      end
      if (u8_in_valid && u8_in_ready)
        q8.push_back(model(8, u8_A, u8_B, u8_Cin, u8_SUB));
    end
  end

  // Scoreboard 32/8
  always @(negedge clk) begin
    if (!rst_n) begin
      q32.delete();
    end else begin
      if (u32_out_valid) begin
        chk("u32 result expected", 64'(q32.size() != 0), 64'd1);
        if (q32.size() != 0) begin
          chk("u32 result", {u32_OVF, u32_Cout, u32_S}, q32[0]);
          if (u32_out_ready) begin
            void'(q32.pop_front());
            n32++;
          end
        end
      end
      if (u32_in_valid && u32_in_ready)
        q32.push_back(model(32, u32_A, u32_B, u32_Cin, u32_SUB));
    end
  end

  // Present a vector on the 16/4 instance and hold it until accepted
  task automatic send16(logic [15:0] a, logic [15:0] b, logic cin, logic sub);
    int w = 0;
    u16_A = a; u16_B = b; u16_Cin = cin; u16_SUB = sub; u16_in_valid = 1'b1;
    @(negedge clk);
    while (!u16_in_ready && w < 50) begin @(negedge clk); w++; end
    chk("u16 accept timeout", 64'(w < 50), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic send8(logic [7:0] a, logic [7:0] b, logic cin, logic sub);
    int w = 0;
    u8_A = a; u8_B = b; u8_Cin = cin; u8_SUB = sub; u8_in_valid = 1'b1;
    @(negedge clk);
    while (!u8_in_ready && w < 50) begin @(negedge clk); w++; end
    chk("u8 accept timeout", 64'(w < 50), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic send32(logic [31:0] a, logic [31:0] b, logic cin, logic sub);
    int w = 0;
    u32_A = a; u32_B = b; u32_Cin = cin; u32_SUB = sub; u32_in_valid = 1'b1;
    @(negedge clk);
    while (!u32_in_ready && w < 50) begin @(negedge clk); w++; end
    chk("u32 accept timeout", 64'(w < 50), 64'd1);
    @(posedge clk); #1;
  endtask

  // One isolated vector on the 16/4 instance with cycle-exact latency check
  task automatic run16(logic [15:0] a, logic [15:0] b, logic cin, logic sub,
                       logic [15:0] es, logic ec, logic eo);
    u16_A = a; u16_B = b; u16_Cin = cin; u16_SUB = sub; u16_in_valid = 1'b1;
    @(posedge clk); #1;
    u16_in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("u16 early out_valid", 64'(u16_out_valid), 64'd0);
      @(posedge clk); #1;
    end
    chk("u16 out_valid at latency", 64'(u16_out_valid), 64'd1);
    chk("u16 S", 64'(u16_S), 64'(es));
    chk("u16 Cout", 64'(u16_Cout), 64'(ec));
    chk("u16 OVF", 64'(u16_OVF), 64'(eo));
    @(posedge clk); #1;
    chk("u16 single-cycle out_valid", 64'(u16_out_valid), 64'd0);
  endtask

  task automatic drain(int budget);
    int w = 0;
    while ((q16.size() + q8.size() + q32.size()) != 0 && w < budget) begin
      @(posedge clk); #1; w++;
    end
    chk("drain timeout", 64'(w < budget), 64'd1);
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [17:0] held;
    rst_n = 1'b0;
    u16_in_valid = 1'b0; u16_out_ready = 1'b1; u16_A = 16'h0; u16_B = 16'h0; u16_Cin = 1'b0; u16_SUB = 1'b0;
    u8_in_valid = 1'b0;  u8_out_ready = 1'b1;  u8_A = 8'h0;   u8_B = 8'h0;   u8_Cin = 1'b0;  u8_SUB = 1'b0;
    u32_in_valid = 1'b0; u32_out_ready = 1'b1; u32_A = 32'h0; u32_B = 32'h0; u32_Cin = 1'b0; u32_SUB = 1'b0;

    // Reset state
    #2;
    chk("reset u16 out_valid", 64'(u16_out_valid), 64'd0);
    chk("reset u16 in_ready", 64'(u16_in_ready), 64'd1);
    chk("reset u16 S/Cout/OVF", {u16_OVF, u16_Cout, u16_S}, 64'd0);
    chk("reset u8 out_valid", 64'(u8_out_valid), 64'd0);
    chk("reset u32 out_valid", 64'(u32_out_valid), 64'd0);
    chk("reset u32 in_ready", 64'(u32_in_ready), 64'd1);
    #16 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-reset u16 in_ready", 64'(u16_in_ready), 64'd1);

    // Pin the reference model to hand-computed values
    chk("model add wrap",   model(16, 64'hFFFF, 64'h0001, 1'b0, 1'b0), 34'h100000000);
    chk("model signed ovf", model(16, 64'h7FFF, 64'h0001, 1'b0, 1'b0), 34'h200008000);
    chk("model sub borrow", model(16, 64'h0005, 64'h0007, 1'b0, 1'b1), 34'h00000FFFE);
    chk("model sub cin",    model(16, 64'h0009, 64'h0003, 1'b1, 1'b1), 34'h100000005);
    chk("model 8b sub ovf", model(8,  64'h80,   64'h01,   1'b0, 1'b1), 34'h30000007F);

    // Directed vectors on 16/4
    run16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run16(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    run16(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run16(16'h0009, 16'h0003, 1'b1, 1'b1, 16'h0005, 1'b1, 1'b0);
    run16(16'h1234, 16'h0F0F, 1'b1, 1'b0, 16'h2144, 1'b0, 1'b0);

    // Single-stage instance: latency 1
    u8_A = 8'hFF; u8_B = 8'h01; u8_Cin = 1'b0; u8_SUB = 1'b0; u8_in_valid = 1'b1;
    @(posedge clk); #1;
    u8_in_valid = 1'b0;
    chk("u8 out_valid latency 1", 64'(u8_out_valid), 64'd1);
    chk("u8 S", 64'(u8_S), 64'h00);
    chk("u8 Cout", 64'(u8_Cout), 64'd1);
    chk("u8 OVF", 64'(u8_OVF), 64'd0);
    @(posedge clk); #1;
    chk("u8 out_valid drops", 64'(u8_out_valid), 64'd0);
    for (int i = 0; i < 20; i++)
      send8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    u8_in_valid = 1'b0;
    drain(20);
    chk("u8 result count", 64'(n8), 64'd21);

    // Backpressure: 8 back-to-back vectors, 3-cycle stall once out_valid rises
    base = n16;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        u16_in_valid = 1'b0;
      end
      begin
        int w = 0;
        while (!u16_out_valid && w < 20) begin @(posedge clk); #1; w++; end
        chk("bp out_valid rose", 64'(u16_out_valid), 64'd1);
        u16_out_ready = 1'b0;
        held = {u16_OVF, u16_Cout, u16_S};
        #1;
        chk("bp in_ready low", 64'(u16_in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
          @(posedge clk); #1;
          chk("bp in_ready held low", 64'(u16_in_ready), 64'd0);
          chk("bp out_valid held", 64'(u16_out_valid), 64'd1);
          chk("bp outputs held", 64'({u16_OVF, u16_Cout, u16_S}), 64'(held));
        end
        u16_out_ready = 1'b1;
      end
    join
    drain(30);
    chk("bp result count", 64'(n16 - base), 64'd8);

    // Reset mid-operation
    send16(16'h1234, 16'h1111, 1'b0, 1'b0);
    send16(16'h4000, 16'h0FFF, 1'b1, 1'b0);
    send16(16'h0100, 16'h0001, 1'b0, 1'b1);
    u16_in_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst precondition out_valid", 64'(u16_out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst async out_valid", 64'(u16_out_valid), 64'd0);
    chk("rst async S/Cout/OVF", {u16_OVF, u16_Cout, u16_S}, 64'd0);
    chk("rst in_ready", 64'(u16_in_ready), 64'd1);
    #9 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("rst no stale result", 64'(u16_out_valid), 64'd0);
    end
    run16(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);

    // 32/8: 1000 random add/sub vectors under random backpressure
    fork
      begin
        for (int i = 0; i < 1000; i++)
          send32($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        u32_in_valid = 1'b0;
        done32 = 1'b1;
      end
      begin
        while (!done32) begin
          @(posedge clk); #1;
          u32_out_ready = ($urandom_range(0, 3) != 0);
        end
        u32_out_ready = 1'b1;
      end
    join
    drain(40);
    chk("u32 result count", 64'(n32), 64'd1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
